// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU: fetch state encoding,
// opcode field location, the halt word and the default two-word opcode set.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_IMM     = 2'd1,
        S_PRESENT = 2'd2,
        S_HALT    = 2'd3
    } fetch_state_t;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

    localparam logic [15:0] CPU_HALT_WORD     = 16'hFFFF;
    // Opcodes 0, 2, 6 and 7 carry an immediate word.
    localparam logic [15:0] CPU_TWO_WORD_MASK = 16'h00C5;

    // True when the opcode field of word selects a set bit in mask.
    function automatic logic opc_has_imm(input logic [15:0] word, input logic [15:0] mask);
        return mask[word[OPC_HI:OPC_LO]];
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction ROM, assembles one- or
// two-word instructions and presents them over a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_FETCH   | read opcode word at pc (bounds check, halt check)
// S_IMM     | read immediate word at pc for a two-word opcode
// S_PRESENT | bundle valid, held stable until ir_ready
// S_HALT    | halt word seen or pc out of range; only reset exits
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ROM_DEPTH     = 20,
    parameter int          PC_W          = 5,
    parameter logic [15:0] TWO_WORD_MASK = CPU_TWO_WORD_MASK,
    parameter logic [15:0] HALT_WORD     = CPU_HALT_WORD
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_data,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [15:0]     ir,
    output logic [15:0]     imm,
    output logic            has_imm,
    output logic [PC_W-1:0] ir_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    output logic            fault
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(ROM_DEPTH - 1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic            pc_oob;
    logic            word_two;

    // The bounds check guards every ROM read, so pc+1 never needs to wrap.
    assign rom_addr = pc;
    assign pc_oob   = (pc > PC_LAST);
    assign word_two = opc_has_imm(rom_data, TWO_WORD_MASK);

    // Fetch sequencer; redirect outranks everything except the halt state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir_valid <= 1'b0;
            ir       <= '0;
            imm      <= '0;
            has_imm  <= 1'b0;
            ir_pc    <= '0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else if (redirect_valid && (state != S_HALT)) begin
            // A coinciding handshake still completes: the consumer already owns the bundle.
            pc       <= redirect_pc;
            state    <= S_FETCH;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (pc_oob) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else if (rom_data == HALT_WORD) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        ir    <= rom_data;
                        ir_pc <= pc;
                        pc    <= pc + PC_ONE;
                        if (word_two) begin
                            state <= S_IMM;
                        end else begin
                            imm      <= '0;
                            has_imm  <= 1'b0;
                            ir_valid <= 1'b1;
                            state    <= S_PRESENT;
                        end
                    end
                end
                S_IMM: begin
                    // The immediate is data, so it is never compared against the halt word.
                    if (pc_oob) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        imm      <= rom_data;
                        has_imm  <= 1'b1;
                        pc       <= pc + PC_ONE;
                        ir_valid <= 1'b1;
                        state    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    ir_valid <= 1'b0;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
